// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline stage register
package pipe_pkg;

   localparam int unsigned PIPE_WIDTH_DEF = 32;
   localparam int unsigned PIPE_CNT_W_DEF = 16;

   typedef logic [1:0] pipe_state_t;

   // Encoding doubles as the held-beat count driven onto Occupancy.
   localparam pipe_state_t ST_EMPTY = 2'b00;
   localparam pipe_state_t ST_ONE   = 2'b01;
   localparam pipe_state_t ST_TWO   = 2'b10;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with synchronous clear
module pipe_sat_counter
   import pipe_pkg::*;
#(
   parameter int unsigned CNT_W = PIPE_CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear wins over increment; the count sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with optional skid buffer
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH      = PIPE_WIDTH_DEF,
   parameter bit          SKID       = 1'b1,
   parameter bit          CLEAR_DATA = 1'b1,
   parameter int unsigned CNT_W      = PIPE_CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InData,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData,
   input  logic             Flush,
   input  logic             CntClr,
   output logic [1:0]       Occupancy,
   output logic [CNT_W-1:0] StallCycles
);

   logic in_xfer;
   logic out_xfer;

   assign in_xfer  = InValid && InReady;
   assign out_xfer = OutValid && OutReady;

   if (SKID) begin : gen_skid
      pipe_state_t      state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;

      // Next state and payload; main always feeds OutData, skid absorbs the overflow beat.
      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         skid_d  = skid_q;
         if (Flush) begin
            state_d = ST_EMPTY;
            if (CLEAR_DATA) begin
               main_d = '0;
               skid_d = '0;
            end
         end else begin
            case (state_q)
               ST_EMPTY: begin
                  if (in_xfer) begin
                     state_d = ST_ONE;
                     main_d  = InData;
                  end
               end
               ST_ONE: begin
                  if (in_xfer && !out_xfer) begin
                     state_d = ST_TWO;
                     skid_d  = InData;
                  end else if (out_xfer && !in_xfer) begin
                     state_d = ST_EMPTY;
                  end else if (in_xfer && out_xfer) begin
                     main_d = InData;
                  end
               end
               ST_TWO: begin
                  if (out_xfer) begin
                     state_d = ST_ONE;
                     main_d  = skid_q;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end
      end

      // Occupancy state register.
      always_ff @(posedge Clk or negedge Rst) begin
         if (!Rst) begin
            state_q <= ST_EMPTY;
         end else begin
            state_q <= state_d;
         end
      end

      if (CLEAR_DATA) begin : gen_clr
         // Payload registers, cleared by reset.
         always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
               main_q <= '0;
               skid_q <= '0;
            end else begin
               main_q <= main_d;
               skid_q <= skid_d;
            end
         end
      end else begin : gen_hold
         // Payload registers without reset; validity is tracked by the state alone.
         always_ff @(posedge Clk) begin
            main_q <= main_d;
            skid_q <= skid_d;
         end
      end

      // Ready comes straight from a flop, so upstream never sees OutReady combinationally.
      assign InReady   = (state_q != ST_TWO);
      assign OutValid  = (state_q != ST_EMPTY);
      assign OutData   = main_q;
      assign Occupancy = state_q;
   end else begin : gen_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] data_q, data_d;

      // Single slot: a new beat may replace the departing one in the same cycle.
      always_comb begin
         valid_d = valid_q;
         data_d  = data_q;
         if (Flush) begin
            valid_d = 1'b0;
            if (CLEAR_DATA) begin
               data_d = '0;
            end
         end else if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = InData;
         end else if (out_xfer) begin
            valid_d = 1'b0;
         end
      end

      // Valid flag register.
      always_ff @(posedge Clk or negedge Rst) begin
         if (!Rst) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_d;
         end
      end

      if (CLEAR_DATA) begin : gen_clr
         // Payload register, cleared by reset.
         always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
               data_q <= '0;
            end else begin
               data_q <= data_d;
            end
         end
      end else begin : gen_hold
         // Payload register without reset.
         always_ff @(posedge Clk) begin
            data_q <= data_d;
         end
      end

      assign InReady   = !valid_q || OutReady;
      assign OutValid  = valid_q;
      assign OutData   = data_q;
      assign Occupancy = {1'b0, valid_q};
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .inc_i (OutValid && !OutReady),
      .clr_i (CntClr),
      .cnt_o (StallCycles)
   );

endmodule
